// File: rtl/dfr_matrix_multiply.sv
// DFR output layer: Y = X * W in signed fixed point with one shared MAC.
// X/W come from 1-cycle-latency read ports; Y goes out one element at a time.
module dfr_matrix_multiply #(
    parameter int ADDR_WIDTH    = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int X_ROWS        = 5,
    parameter int Y_COLS        = 5,
    parameter int X_COLS_Y_ROWS = 5,
    parameter int FRAC_BITS     = 16,
    parameter int ACC_WIDTH     = 72
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] x_addr,
    input  logic [DATA_WIDTH-1:0] x_data,
    output logic [ADDR_WIDTH-1:0] w_addr,
    input  logic [DATA_WIDTH-1:0] w_data,
    output logic [ADDR_WIDTH-1:0] y_addr,
    output logic [DATA_WIDTH-1:0] y_data,
    output logic                  y_wen
);

    localparam int K  = X_COLS_Y_ROWS;
    localparam int IW = $clog2(X_ROWS + 1);
    localparam int JW = $clog2(Y_COLS + 1);
    localparam int KW = $clog2(K + 1);
    localparam int PW = 2 * DATA_WIDTH;

    if (X_ROWS < 1 || Y_COLS < 1 || K < 1) begin : g_bad_dims
        $error("dfr_matrix_multiply: every dimension must be at least 1");
    end
    if (ACC_WIDTH < PW + $clog2(K + 1)) begin : g_bad_acc
        $error("dfr_matrix_multiply: ACC_WIDTH too narrow for K products");
    end

    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
        ACC_WIDTH'({1'b0, {(DATA_WIDTH-1){1'b1}}});
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACC,
        S_LAST,
        S_WRITE,
        S_DONE
    } state_t;

    state_t                        state_q, state_d;
    logic [IW-1:0]                 i_q, i_d;
    logic [JW-1:0]                 j_q, j_d;
    logic [KW-1:0]                 k_q, k_d;
    logic signed [ACC_WIDTH-1:0]   acc_q, acc_d;
    logic                          pv_q, pv_d;
    logic [ADDR_WIDTH-1:0]         xa_q, xa_d;
    logic [ADDR_WIDTH-1:0]         wa_q, wa_d;
    logic [ADDR_WIDTH-1:0]         ya_q, ya_d;
    logic [DATA_WIDTH-1:0]         yd_q, yd_d;

    logic signed [PW-1:0]          prod;
    logic signed [ACC_WIDTH-1:0]   prod_ext;
    logic signed [ACC_WIDTH-1:0]   shifted;
    logic                          last_elem;

    assign prod     = PW'($signed(x_data)) * PW'($signed(w_data));
    assign prod_ext = ACC_WIDTH'(prod);

    assign last_elem = (i_q == IW'(X_ROWS - 1)) && (j_q == JW'(Y_COLS - 1));

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        k_d     = k_q;
        acc_d   = acc_q;
        pv_d    = 1'b0;
        xa_d    = xa_q;
        wa_d    = wa_q;
        ya_d    = ya_q;
        yd_d    = yd_q;
        shifted = '0;

        if (pv_q) begin
            acc_d = acc_q + prod_ext;
        end

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_ACC;
                    i_d     = '0;
                    j_d     = '0;
                    k_d     = '0;
                    acc_d   = '0;
                    xa_d    = '0;
                    wa_d    = '0;
                end
            end
            // address registers already hold element k; prefetch k+1
            S_ACC: begin
                pv_d = 1'b1;
                if (k_q == KW'(K - 1)) begin
                    state_d = S_LAST;
                end else begin
                    k_d  = k_q + KW'(1);
                    xa_d = xa_q + ADDR_WIDTH'(1);
                    wa_d = wa_q + ADDR_WIDTH'(Y_COLS);
                end
            end
            S_LAST: begin
                state_d = S_WRITE;
                ya_d    = ADDR_WIDTH'(i_q) * ADDR_WIDTH'(Y_COLS)
                        + ADDR_WIDTH'(j_q);
                shifted = acc_d >>> FRAC_BITS;
                if (shifted > SAT_MAX) begin
                    yd_d = SAT_MAX[DATA_WIDTH-1:0];
                end else if (shifted < SAT_MIN) begin
                    yd_d = SAT_MIN[DATA_WIDTH-1:0];
                end else begin
                    yd_d = shifted[DATA_WIDTH-1:0];
                end
            end
            S_WRITE: begin
                acc_d = '0;
                k_d   = '0;
                if (j_q == JW'(Y_COLS - 1)) begin
                    j_d = '0;
                    i_d = i_q + IW'(1);
                end else begin
                    j_d = j_q + JW'(1);
                end
                if (last_elem) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_ACC;
                    xa_d    = ADDR_WIDTH'(i_d) * ADDR_WIDTH'(K);
                    wa_d    = ADDR_WIDTH'(j_d);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            acc_q   <= '0;
            pv_q    <= 1'b0;
            xa_q    <= '0;
            wa_q    <= '0;
            ya_q    <= '0;
            yd_q    <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            k_q     <= k_d;
            acc_q   <= acc_d;
            pv_q    <= pv_d;
            xa_q    <= xa_d;
            wa_q    <= wa_d;
            ya_q    <= ya_d;
            yd_q    <= yd_d;
        end
    end

    assign busy   = (state_q != S_IDLE);
    assign done   = (state_q == S_DONE);
    assign y_wen  = (state_q == S_WRITE);
    assign x_addr = xa_q;
    assign w_addr = wa_q;
    assign y_addr = ya_q;
    assign y_data = yd_q;

endmodule
